// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 block padder: FSM state encoding
// and the byte positions that shape a padded 512-bit block.
package md5_pkg;

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    PAD80   = 3'd1,
    PADZ    = 3'd2,
    LEN     = 3'd3,
    EMIT    = 3'd4
  } state_t;

  localparam int                 BLOCK_BYTES = 64;
  localparam int                 IDX_W       = $clog2(BLOCK_BYTES);
  localparam logic [IDX_W-1:0]   LEN_POS     = IDX_W'(56);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(BLOCK_BYTES - 1);
  localparam logic [7:0]         PAD_BYTE    = 8'h80;

endpackage

// File: rtl/md5_byte_buffer.sv
// 64x8 block buffer: one indexed byte write per cycle, whole block readable
// flat with byte k at [8k+7:8k].
module md5_byte_buffer
  import md5_pkg::*;
(
  input  logic                   Clk,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [7:0]             wr_data,
  output logic [8*BLOCK_BYTES-1:0] flat
);

  // No reset: every position is rewritten before a block is presented.
  logic [8*BLOCK_BYTES-1:0] mem;

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[{wr_idx, 3'b000} +: 8] <= wr_data;
    end
  end

  assign flat = mem;

endmodule

// File: rtl/md5_block_padder.sv
// MD5 message padder: collects a byte stream, appends 0x80, zero fill and the
// 64-bit little-endian bit length, and hands out 512-bit blocks one at a time.
module md5_block_padder
  import md5_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last,
  output state_t       fsm_state
);

  // Handshake: a transfer happens on a rising Clk edge where valid & ready
  // are both high; valid never depends on ready, and block outputs stay
  // stable from the rise of blk_valid until the transfer.

  state_t             state, state_n;
  state_t             ret_state, ret_state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [LEN_W-1:0]   byte_cnt, byte_cnt_n;
  logic               first_pending, first_pending_n;
  logic               last_flag, last_flag_n;

  logic               wr_en;
  logic [7:0]         wr_data;
  logic [511:0]       buf_flat;
  logic [63:0]        bit_len;

  assign bit_len = 64'({byte_cnt, 3'b000});

  md5_byte_buffer u_buf (
    .Clk     (Clk),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_data (wr_data),
    .flat    (buf_flat)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state         <= COLLECT;
      ret_state     <= COLLECT;
      idx           <= '0;
      byte_cnt      <= '0;
      first_pending <= 1'b1;
      last_flag     <= 1'b0;
    end else begin
      state         <= state_n;
      ret_state     <= ret_state_n;
      idx           <= idx_n;
      byte_cnt      <= byte_cnt_n;
      first_pending <= first_pending_n;
      last_flag     <= last_flag_n;
    end
  end

  always_comb begin
    state_n         = state;
    ret_state_n     = ret_state;
    idx_n           = idx;
    byte_cnt_n      = byte_cnt;
    first_pending_n = first_pending;
    last_flag_n     = last_flag;
    wr_en           = 1'b0;
    wr_data         = in_byte;

    case (state)
      COLLECT: begin
        if (in_valid) begin
          wr_en      = 1'b1;
          idx_n      = idx + IDX_W'(1);
          byte_cnt_n = byte_cnt + LEN_W'(1);
          if (idx == LAST_IDX) begin
            state_n     = EMIT;
            ret_state_n = in_last ? PAD80 : COLLECT;
          end else if (in_last) begin
            state_n = PAD80;
          end
        end
      end

      PAD80: begin
        wr_en   = 1'b1;
        wr_data = PAD_BYTE;
        idx_n   = idx + IDX_W'(1);
        if (idx == LAST_IDX) begin
          state_n     = EMIT;
          ret_state_n = PADZ;
        end else begin
          state_n = PADZ;
        end
      end

      PADZ: begin
        if (idx == LEN_POS) begin
          state_n = LEN;
        end else begin
          wr_en   = 1'b1;
          wr_data = 8'h00;
          idx_n   = idx + IDX_W'(1);
          // 0x80 landed too late for the length field: spill into a new block.
          if (idx == LAST_IDX) begin
            state_n     = EMIT;
            ret_state_n = PADZ;
          end
        end
      end

      LEN: begin
        wr_en   = 1'b1;
        wr_data = bit_len[{idx[2:0], 3'b000} +: 8];
        idx_n   = idx + IDX_W'(1);
        if (idx == LAST_IDX) begin
          last_flag_n = 1'b1;
          state_n     = EMIT;
          ret_state_n = COLLECT;
        end
      end

      EMIT: begin
        if (blk_ready) begin
          first_pending_n = 1'b0;
          state_n         = ret_state;
          if (last_flag) begin
            first_pending_n = 1'b1;
            byte_cnt_n      = '0;
            last_flag_n     = 1'b0;
          end
        end
      end

      default: begin
        state_n = COLLECT;
      end
    endcase
  end

  assign in_ready  = (state == COLLECT);
  assign blk_valid = (state == EMIT);
  assign blk_first = blk_valid & first_pending;
  assign blk_last  = blk_valid & last_flag;
  assign blk_data  = blk_valid ? buf_flat : '0;
  assign fsm_state = state;

endmodule

// File: tb/tb_md5_block_padder.sv
// Directed bench for md5_block_padder: hand-built expected blocks are queued
// and compared against blocks captured at the output handshake.
module tb_md5_block_padder;
  import md5_pkg::*;

  localparam int W = 514;  // {first, last, data}

  logic         Clk;
  logic         Rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_byte;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  state_t       fsm_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           errors;
  int           checks;

  md5_block_padder #(.LEN_W(32)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .in_last   (in_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic do_reset(input int cycles);
    Rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_byte  = 8'h00;
    repeat (cycles) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output monitor: inputs change #1 after posedge, so a negedge sample
  // predicts the handshake on the following posedge.
  always @(negedge Clk) begin
    if (Rst_n && blk_valid && blk_ready) begin
      got_q.push_back({blk_first, blk_last, blk_data});
    end
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge Clk);
      #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", W'(0), W'(1));
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_abc();
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
  endtask

  task automatic drain_and_compare(input string tag, input int nblk);
    int c;
    c = 0;
    while (got_q.size() < nblk && c < 400) begin
      @(posedge Clk);
      #1;
      c++;
    end
    repeat (2) @(posedge Clk);
    #1;
    check({tag, "_count"}, W'(got_q.size()), W'(nblk));
    for (int i = 0; i < nblk; i++) begin
      if (got_q.size() > 0 && exp_q.size() > 0)
        check($sformatf("%s_blk%0d", tag, i), got_q.pop_front(), exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [W-1:0] abc_block();
    logic [511:0] d;
    d = '0;
    d[31:0]    = 32'h80636261;
    d[479:448] = 32'h00000018;
    return {1'b1, 1'b1, d};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [511:0] d;
    logic [511:0] held;
    int           lat;
    errors    = 0;
    checks    = 0;
    blk_ready = 1'b1;
    do_reset(3);

    check("rst_blk_valid", W'(blk_valid), W'(0));
    check("rst_in_ready",  W'(in_ready),  W'(1));
    check("rst_blk_first", W'(blk_first), W'(0));
    check("rst_blk_last",  W'(blk_last),  W'(0));
    check("rst_blk_data",  W'(blk_data),  W'(0));
    check("rst_state",     W'(fsm_state), W'(COLLECT));

    // 1: "abc", plus latency from the in_last transfer to blk_valid
    exp_q.push_back(abc_block());
    send_abc();
    lat = 0;
    while (!blk_valid && lat < 200) begin
      @(posedge Clk);
      #1;
      lat++;
    end
    check("abc_latency", W'(lat), W'(62));
    drain_and_compare("abc", 1);

    // 2: 55 x 0x41 -> one block
    d = '0;
    for (int k = 0; k < 55; k++) d[8*k +: 8] = 8'h41;
    d[8*55 +: 8] = 8'h80;
    d[8*56 +: 8] = 8'hB8;
    d[8*57 +: 8] = 8'h01;
    exp_q.push_back({1'b1, 1'b1, d});
    for (int k = 0; k < 55; k++) send_byte(8'h41, k == 54);
    drain_and_compare("len55", 1);

    // 3: 56 x 0x41 -> two blocks
    d = '0;
    for (int k = 0; k < 56; k++) d[8*k +: 8] = 8'h41;
    d[8*56 +: 8] = 8'h80;
    exp_q.push_back({1'b1, 1'b0, d});
    d = '0;
    d[8*56 +: 8] = 8'hC0;
    d[8*57 +: 8] = 8'h01;
    exp_q.push_back({1'b0, 1'b1, d});
    for (int k = 0; k < 56; k++) send_byte(8'h41, k == 55);
    drain_and_compare("len56", 2);

    // 4: 64 bytes 0x00..0x3F -> data block then pad-only block
    d = '0;
    for (int k = 0; k < 64; k++) d[8*k +: 8] = 8'(k);
    exp_q.push_back({1'b1, 1'b0, d});
    d = '0;
    d[7:0]       = 8'h80;
    d[8*57 +: 8] = 8'h02;
    exp_q.push_back({1'b0, 1'b1, d});
    for (int k = 0; k < 64; k++) send_byte(8'(k), k == 63);
    drain_and_compare("len64", 2);

    // 5: "abc" under backpressure
    blk_ready = 1'b0;
    exp_q.push_back(abc_block());
    send_abc();
    lat = 0;
    while (!blk_valid && lat < 200) begin
      @(posedge Clk);
      #1;
      lat++;
    end
    check("bp_valid_rise", W'(blk_valid), W'(1));
    held = blk_data;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_valid_c%0d", c), W'(blk_valid), W'(1));
      check($sformatf("bp_ready_c%0d", c), W'(in_ready), W'(0));
      check($sformatf("bp_data_c%0d", c), W'(blk_data), W'(held));
      @(posedge Clk);
      #1;
    end
    blk_ready = 1'b1;
    @(posedge Clk);
    #1;
    check("bp_valid_fall", W'(blk_valid), W'(0));
    check("bp_in_ready",   W'(in_ready),  W'(1));
    drain_and_compare("bp", 1);

    // 6: partial message discarded by a mid-message reset
    for (int k = 0; k < 10; k++) send_byte(8'hA5, 1'b0);
    do_reset(1);
    check("mid_rst_no_block", W'(got_q.size()), W'(0));
    check("mid_rst_in_ready", W'(in_ready), W'(1));
    exp_q.push_back(abc_block());
    send_abc();
    drain_and_compare("after_rst", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md5_block_padder.md
Name: md5_block_padder

Overview:
- Upstream neighbour of the MD5 processing element (PE).
- Accepts a byte stream per message, applies MD5 padding (0x80, zero fill, 64-bit little-endian bit length), and emits 512-bit blocks ready for the PE's M0..M15 word slicing.
- Multi-block messages are produced one block at a time under a valid/ready handshake.
- blk_first and blk_last tell the core when to reload the IV and when the digest is final.

Parameters:
LEN_W, 32, byte-counter width; bit length = {byte_cnt,3'b000}, zero-extended to 64 bits; the counter wraps modulo 2^LEN_W.

Ports:
Clk  in  1  clock; all logic on posedge.
Rst_n  in  1  synchronous active-low reset.
in_valid  in  1  in_byte/in_last valid.
in_ready  out  1  padder accepts a byte this cycle.
in_byte  in  8  message byte, in stream order.
in_last  in  1  marks the final byte of the message; messages are at least 1 byte.
blk_valid  out  1  blk_data holds a complete block.
blk_ready  in  1  consumer takes the block.
blk_data  out  512  stream byte k of the block at [8k+7:8k], so M0 = [31:0] and M15 = [511:480].
blk_first  out  1  block is the first of its message.
blk_last  out  1  block is the final, padded block of its message.

Behaviour:
- Reset is synchronous, active-low, on Clk; Rst_n is sampled at posedge.
- Reset values: state COLLECT, idx 0, byte_cnt 0, first_pending 1, blk_valid 0, blk_first 0, blk_last 0, blk_data 0.
- Reset mid-operation discards any partial message and any un-handshaken block.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when blk_valid & blk_ready.
  - in_ready = (state == COLLECT).
- COLLECT, on each transfer:
  - Write buf[idx] = in_byte; idx++ (6-bit, wraps); byte_cnt++.
  - If idx was 63: go to EMIT; return state is PAD80 if in_last, else COLLECT.
  - Else if in_last: go to PAD80.
- PAD80 (1 cycle): write buf[idx] = 8'h80; idx++. If idx was 63, go to EMIT with return PADZ; else go to PADZ.
- PADZ:
  - If idx == 56: go to LEN with no write.
  - Else write 8'h00, idx++. If idx was 63, go to EMIT with return PADZ (an extra block is needed when 0x80 lands at index ≥ 56).
- LEN (8 cycles): buf[idx] = bitlen[8*(idx-56)+:8], least-significant byte first. At idx 63, set last_flag and go to EMIT with return COLLECT.
- EMIT:
  - blk_valid = 1. blk_data, blk_first and blk_last are held stable until the handshake.
  - blk_first = first_pending.
  - On handshake: clear first_pending. If this was the last block, set first_pending = 1 and clear byte_cnt. Go to the return state. blk_valid falls the next cycle.
- Backpressure: while in EMIT, in_ready = 0 and no buffer writes occur.
- Throughput/latency:
  - One byte or pad byte per cycle; EMIT costs at least 1 cycle.
  - The final block appears (64 − idx_at_last) cycles after the in_last transfer.
- The buffer is not cleared between blocks; every byte position is rewritten before each EMIT.

Decomposition:
- md5_pkg holds: state enum (COLLECT, PAD80, PADZ, LEN, EMIT), BLOCK_BYTES = 64, LEN_POS = 56, PAD_BYTE = 8'h80.
- One natural sub-module, md5_byte_buffer: 64×8 register file with indexed single-byte write and a flat 512-bit read.

Test Plan:
1. "abc" (61 62 63, last on 63) → one block: blk_first = blk_last = 1; M0 = 32'h80636261, M1..M13 = 0, M14 = 32'h00000018, M15 = 0.
2. 55 bytes of 8'h41 → one block: byte 55 = 8'h80, byte 56 = 8'hB8, byte 57 = 8'h01, bytes 58..63 = 0.
3. 56 bytes of 8'h41 → two blocks:
   - Block 1: byte 56 = 8'h80, bytes 57..63 = 0, blk_first = 1, blk_last = 0.
   - Block 2: bytes 0..55 = 0, byte 56 = 8'hC0, byte 57 = 8'h01, blk_first = 0, blk_last = 1.
4. 64 bytes of 8'h00..8'h3F → two blocks:
   - Block 1 is the data unchanged.
   - Block 2: byte 0 = 8'h80, byte 57 = 8'h02, others 0.
5. "abc" with blk_ready held low for 5 cycles after blk_valid rises → blk_valid stays 1, blk_data unchanged, in_ready = 0; handshake on cycle 6, then in_ready = 1 next cycle.
6. 10 bytes sent, Rst_n = 0 for 1 cycle, then "abc" → no block output before the reset; after it, exactly the block from scenario 1 with blk_first = 1.
